memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Memory pipeline stage: E->M pipeline register, data-memory access, and load-data reduction.
//  Sits between execute_stage and writeback_stage, and produces every *_m_i input that writeback consumes.
//  Issues one req/ack transaction per valid load/store and holds mem_busy_o high until the ack arrives.
//  The hazard unit uses mem_busy_o to stall F..M.
// PARAMETERS
//  TIMEOUT_CYCLES  64  wait-state limit before bus_err_o; 0 = no timeout
// PORTS
//  clk_i           in   1   clock; all state on posedge
//  reset_ni        in   1   asynchronous active-low reset
//  instr_e_i       in   32  instruction from execute
//  alu_result_e_i  in   32  ALU result / effective address
//  write_data_e_i  in   32  store data (rs2)
//  pc_target_e_i, pc_plus4_e_i, imm_ext_e_i, csr_result_e_i, csr_data_e_i  in  32  passthrough data
//  csr_addr_e_i    in   12  CSR address passthrough
//  rd_e_i          in   5   destination register
//  valid_e_i, reg_write_e_i, csr_we_e_i, mem_write_e_i, mem_read_e_i  in  1  control
//  result_src_e_i  in   3   result mux select passthrough
//  width_e_i       in   3   funct3 access width/sign
//  stall_m_i       in   1   hold M register
//  flush_m_i       in   1   bubble M register (priority over stall)
//  *_m_o           out  —   registered counterparts of every *_e_i above except mem_*/width, same widths
//  reduced_data_m_o out 32  load data, extended/aligned (combinational)
//  dmem_req_o      out  1   memory request
//  dmem_we_o       out  1   1 = store
//  dmem_addr_o     out  32  word address {alu_result_m[31:2],2'b00}
//  dmem_wdata_o    out  32  lane-replicated store data
//  dmem_be_o       out  4   byte enables
//  dmem_ack_i      in   1   request accepted/completed
//  dmem_rdata_i    in   32  read word, valid with ack
//  mem_busy_o      out  1   access outstanding, stall request
//  bus_err_o       out  1   one-cycle timeout pulse
//  misaligned_o    out  1   misaligned access flag
// BEHAVIOUR
//  Reset: all registered outputs 0, FSM IDLE, req/we/be/busy/bus_err/misaligned 0.
//  M register update priority: flush_m_i clears valid, reg_write, csr_we, mem_read, mem_write;
//   otherwise, if ~stall_m_i & ~mem_busy_o, load *_e_i; otherwise hold.
//  access = valid_m & (mem_read_m | mem_write_m) & ~misaligned_o.
//  FSM IDLE:
//   - access & ~done_q -> req=1 combinationally.
//   - ack same cycle -> capture rdata, go DONE, busy=0 (zero-wait path).
//   - no ack -> go WAIT, busy=1.
//  FSM WAIT:
//   - req, addr, wdata and be held stable; busy=1; wait counter increments.
//   - on ack -> capture rdata into rdata_q, go DONE.
//  FSM DONE: req=0; return to IDLE when the M register next loads or flushes.
//  Timeout: if TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES in WAIT:
//   - bus_err_o pulses 1 cycle, rdata_q=0, go DONE, req drops.
//  Flush in WAIT: req stays high until ack (never retracted); captured data discarded.
//   M bubbles once busy clears.
//  Async reset mid-WAIT: immediate IDLE, req=0; no ack is expected afterwards.
//  Loads (funct3, lane = addr[1:0]):
//   - 000 LB: sign-extend byte.  100 LBU: zero-extend byte.
//   - 001 LH: sign-extend half at addr[1].  101 LHU: zero-extend half.
//   - 010 LW: full word.  others: 0.
//  reduced_data_m_o selects dmem_rdata_i in the ack cycle, rdata_q otherwise.
//  Stores:
//   - SB: be = 4'b0001<<addr[1:0], byte replicated x4.
//   - SH: be = 4'b0011<<{addr[1],1'b0}, half replicated x2.
//   - SW: be = 4'b1111.
//  Loads: dmem_we_o=0, be=4'b1111.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0 -> misaligned_o=1 while valid_m.
//   - No request issued; reg_write_m_o forced 0.
//  Undefined: misaligned_o tied 0; halfword uses addr[1] only; word ignores addr[1:0].
// TESTING
//  LW 0x100, ack same cycle, rdata 0xDEADBEEF -> reduced 0xDEADBEEF, mem_busy_o never 1.
//  LB 0x103, ack after 3 cycles, rdata 0x80123456:
//   - mem_busy_o high 3 cycles, reduced 0xFFFFFF80.
//   - Repeat as LBU -> 0x00000080.
//  SH 0x202, data 0x1234ABCD -> dmem_be_o=4'b1100, dmem_wdata_o=0xABCDABCD, dmem_we_o=1.
//  flush_m_i in WAIT:
//   - req stays 1 until ack at cycle 5; next cycle valid_m_o=0, reg_write_m_o=0.
//   - reset_ni low mid-WAIT -> req=0 immediately.
//  No ack, TIMEOUT_CYCLES=64 -> bus_err_o one pulse at wait cycle 64, then busy=0, reduced=0.
//  LW 0x101:
//   - with MEM_MISALIGN_TRAP_EN -> misaligned_o=1, dmem_req_o=0.
//   - without -> req with dmem_addr_o=0x100.

Source files
------------

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - E->M pipeline register, data-memory req/ack FSM and load-data reduction
// Optional feature: define MEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of issuing them.
`timescale 1ns/1ps
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] instr_e_i,
    input  logic [31:0] alu_result_e_i,
    input  logic [31:0] write_data_e_i,
    input  logic [31:0] pc_target_e_i,
    input  logic [31:0] pc_plus4_e_i,
    input  logic [31:0] imm_ext_e_i,
    input  logic [31:0] csr_result_e_i,
    input  logic [31:0] csr_data_e_i,
    input  logic [11:0] csr_addr_e_i,
    input  logic [4:0]  rd_e_i,
    input  logic        valid_e_i,
    input  logic        reg_write_e_i,
    input  logic        csr_we_e_i,
    input  logic        mem_write_e_i,
    input  logic        mem_read_e_i,
    input  logic [2:0]  result_src_e_i,
    input  logic [2:0]  width_e_i,
    input  logic        stall_m_i,
    input  logic        flush_m_i,
    output logic [31:0] instr_m_o,
    output logic [31:0] alu_result_m_o,
    output logic [31:0] write_data_m_o,
    output logic [31:0] pc_target_m_o,
    output logic [31:0] pc_plus4_m_o,
    output logic [31:0] imm_ext_m_o,
    output logic [31:0] csr_result_m_o,
    output logic [31:0] csr_data_m_o,
    output logic [11:0] csr_addr_m_o,
    output logic [4:0]  rd_m_o,
    output logic        valid_m_o,
    output logic        reg_write_m_o,
    output logic        csr_we_m_o,
    output logic [2:0]  result_src_m_o,
    output logic [31:0] reduced_data_m_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        mem_busy_o,
    output logic        bus_err_o,
    output logic        misaligned_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam int            CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state, state_next;
    logic          mem_read_m, mem_write_m, reg_write_m;
    logic [2:0]    width_m;
    logic [31:0]   rdata_q;
    logic [CW-1:0] wait_cnt;
    logic          flush_pend, flush_eff, m_bubble, m_load, m_update;
    logic          access, timeout, ack_take;
    logic [3:0]    be;
    logic [31:0]   rsrc;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;

    // A flush that lands while an access is outstanding is remembered and applied once busy clears.
    assign flush_eff = flush_m_i | flush_pend;
    assign m_bubble  = flush_eff & ~mem_busy_o;
    assign m_load    = ~flush_eff & ~stall_m_i & ~mem_busy_o;
    assign m_update  = m_bubble | m_load;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            instr_m_o      <= '0;
            alu_result_m_o <= '0;
            write_data_m_o <= '0;
            pc_target_m_o  <= '0;
            pc_plus4_m_o   <= '0;
            imm_ext_m_o    <= '0;
            csr_result_m_o <= '0;
            csr_data_m_o   <= '0;
            csr_addr_m_o   <= '0;
            rd_m_o         <= '0;
            valid_m_o      <= 1'b0;
            reg_write_m    <= 1'b0;
            csr_we_m_o     <= 1'b0;
            mem_write_m    <= 1'b0;
            mem_read_m     <= 1'b0;
            result_src_m_o <= '0;
            width_m        <= '0;
        end else if (m_bubble) begin
            valid_m_o   <= 1'b0;
            reg_write_m <= 1'b0;
            csr_we_m_o  <= 1'b0;
            mem_write_m <= 1'b0;
            mem_read_m  <= 1'b0;
        end else if (m_load) begin
            instr_m_o      <= instr_e_i;
            alu_result_m_o <= alu_result_e_i;
            write_data_m_o <= write_data_e_i;
            pc_target_m_o  <= pc_target_e_i;
            pc_plus4_m_o   <= pc_plus4_e_i;
            imm_ext_m_o    <= imm_ext_e_i;
            csr_result_m_o <= csr_result_e_i;
            csr_data_m_o   <= csr_data_e_i;
            csr_addr_m_o   <= csr_addr_e_i;
            rd_m_o         <= rd_e_i;
            valid_m_o      <= valid_e_i;
            reg_write_m    <= reg_write_e_i;
            csr_we_m_o     <= csr_we_e_i;
            mem_write_m    <= mem_write_e_i;
            mem_read_m     <= mem_read_e_i;
            result_src_m_o <= result_src_e_i;
            width_m        <= width_e_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)      flush_pend <= 1'b0;
        else if (m_update)  flush_pend <= 1'b0;
        else if (flush_m_i) flush_pend <= 1'b1;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned_o = 1'b0;
        if (valid_m_o && (mem_read_m || mem_write_m)) begin
            case (width_m[1:0])
                2'b01:   misaligned_o = alu_result_m_o[0];
                2'b10:   misaligned_o = |alu_result_m_o[1:0];
                default: misaligned_o = 1'b0;
            endcase
        end
    end
`else
    assign misaligned_o = 1'b0;
`endif

    assign reg_write_m_o = reg_write_m & ~misaligned_o;
    assign access        = valid_m_o & (mem_read_m | mem_write_m) & ~misaligned_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state <= S_IDLE;
        else           state <= state_next;
    end

    // Leaving straight to IDLE when M advances in the ack cycle keeps the next access from being skipped.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (access) state_next = dmem_ack_i ? (m_update ? S_IDLE : S_DONE) : S_WAIT;
            S_WAIT: begin
                if (dmem_ack_i)   state_next = m_update ? S_IDLE : S_DONE;
                else if (timeout) state_next = S_DONE;
            end
            S_DONE: if (m_update) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o = 1'b0;
        case (state)
            S_IDLE:  dmem_req_o = access;
            S_WAIT:  dmem_req_o = 1'b1;
            default: dmem_req_o = 1'b0;
        endcase
        ack_take   = dmem_req_o & dmem_ack_i;
        mem_busy_o = dmem_req_o & ~dmem_ack_i;
        timeout    = (TIMEOUT_CYCLES > 0) && (state == S_WAIT) && !dmem_ack_i && (wait_cnt == LIMIT);
        bus_err_o  = timeout;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)             wait_cnt <= '0;
        else if (state != S_WAIT)  wait_cnt <= '0;
        else                       wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)     rdata_q <= '0;
        else if (ack_take) rdata_q <= dmem_rdata_i;
        else if (timeout)  rdata_q <= '0;
    end

    always_comb begin
        be           = 4'b1111;
        dmem_wdata_o = write_data_m_o;
        if (mem_write_m) begin
            case (width_m[1:0])
                2'b00: begin
                    be           = 4'b0001 << alu_result_m_o[1:0];
                    dmem_wdata_o = {4{write_data_m_o[7:0]}};
                end
                2'b01: begin
                    be           = 4'b0011 << {alu_result_m_o[1], 1'b0};
                    dmem_wdata_o = {2{write_data_m_o[15:0]}};
                end
                default: be = 4'b1111;
            endcase
        end
    end

    assign dmem_addr_o = {alu_result_m_o[31:2], 2'b00};
    assign dmem_we_o   = dmem_req_o & mem_write_m;
    assign dmem_be_o   = dmem_req_o ? be : 4'b0000;

    assign rsrc      = ack_take ? dmem_rdata_i : rdata_q;
    assign lane_byte = rsrc[{alu_result_m_o[1:0], 3'b000} +: 8];
    assign lane_half = alu_result_m_o[1] ? rsrc[31:16] : rsrc[15:0];

    always_comb begin
        reduced_data_m_o = '0;
        case (width_m)
            3'b000:  reduced_data_m_o = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  reduced_data_m_o = {24'h0, lane_byte};
            3'b001:  reduced_data_m_o = {{16{lane_half[15]}}, lane_half};
            3'b101:  reduced_data_m_o = {16'h0, lane_half};
            3'b010:  reduced_data_m_o = rsrc;
            default: reduced_data_m_o = '0;
        endcase
    end
endmodule
